// File: rtl/pcs_40g_tx_sched.sv
// ---------------------------------------------------------------------------
// pcs_40g_tx_sched
//
// Transmit slot scheduler for the 40G PCS TX path. Every clk cycle it decides
// whether the current 4-lane block slot carries MAC data, an alignment marker
// (AM) or is a gearbox stall, and drives the datapath strobes accordingly.
//
// The first slot after enabling is always an AM. After that, AM_PERIOD data
// slots separate successive AMs. The gearbox stalls once every GB_PERIOD+1
// cycles on a fixed cadence, and stall cycles are not counted as data slots.
// An AM that falls due on a stall cycle waits for the next non-stall slot.
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   en_i        scheduler enable from link startup (level-sensitive)
//   ready_o     MAC may present a data block; consumed when ready_o=1
//   scr_en_o    scrambler/encoder advance (identical to ready_o)
//   am_v_o      per-lane AM-slot strobe (all bits equal)
//   gb_stall_o  gearbox stall cycle, no block pushed
//   gb_seq_o    gearbox sequence index 0..GB_PERIOD
//   run_o       scheduler is in the RUN state
//
// Every output is taken straight from a flop; en_i never reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module pcs_40g_tx_sched #(
    parameter int LANE_N    = 4,
    parameter int AM_PERIOD = 16383,
    parameter int GB_PERIOD = 32,
    parameter int CNT_W     = $clog2(AM_PERIOD),
    parameter int SEQ_W     = $clog2(GB_PERIOD + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    output logic              ready_o,
    output logic              scr_en_o,
    output logic [LANE_N-1:0] am_v_o,
    output logic              gb_stall_o,
    output logic [SEQ_W-1:0]  gb_seq_o,
    output logic              run_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SEQ_W-1:0] SEQ_STALL = SEQ_W'(GB_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(AM_PERIOD - 1);

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             am_q, am_d;
    logic             ready_q, ready_d;
    logic             stall_q, stall_d;
    logic             cur_stall;

    // Classification of the slot currently being presented.
    assign cur_stall = (seq_q == SEQ_STALL);

    // Next-state logic. The output flops are loaded with the classification
    // of the *next* slot, so the registered outputs always describe the slot
    // that the state registers hold.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        case (state_q)
            IDLE: begin
                seq_d  = '0;
                cnt_d  = '0;
                pend_d = 1'b0;
                if (en_i) begin
                    state_d = RUN;
                    pend_d  = 1'b1;      // first RUN slot is an AM
                end
            end
            RUN: begin
                if (!en_i) begin
                    // Drop any pending AM; the gearbox restarts at 0 later.
                    state_d = IDLE;
                    seq_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    seq_d = cur_stall ? '0 : seq_q + SEQ_W'(1);
                    if (!cur_stall) begin
                        if (pend_q) begin
                            // AM slot
                            pend_d = 1'b0;
                            cnt_d  = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            // Last data slot of the period: next free slot is AM.
                            pend_d = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_d = (state_d == RUN) && (seq_d == SEQ_STALL);
        am_d    = (state_d == RUN) && !stall_d && pend_d;
        ready_d = (state_d == RUN) && !stall_d && !pend_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seq_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            am_q    <= 1'b0;
            ready_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            am_q    <= am_d;
            ready_q <= ready_d;
            stall_q <= stall_d;
        end
    end

    assign run_o      = (state_q == RUN);
    assign ready_o    = ready_q;
    assign scr_en_o   = ready_q;
    assign am_v_o     = {LANE_N{am_q}};
    assign gb_stall_o = stall_q;
    assign gb_seq_o   = seq_q;

endmodule

// File: tb/tb_pcs_40g_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_pcs_40g_tx_sched
//
// Three scheduler instances: AM_PERIOD=7/GB_PERIOD=4, AM_PERIOD=8/GB_PERIOD=4
// and the default 16383/32. Expected per-cycle outputs for the small
// instances come from a slot-walking reference model and are queued when the
// stimulus is driven, then popped and compared once the cycle is presented.
// Directed checks pin the cycle numbers of the documented scenarios. The
// default instance is watched for AM spacing, stall spacing and exclusivity.
// ---------------------------------------------------------------------------
module tb_pcs_40g_tx_sched;

    logic clk;
    logic reset;
    logic en_a;
    logic en_d;

    // AM_PERIOD=7, GB_PERIOD=4
    logic       ready7, scr7, stall7, run7;
    logic [3:0] am7;
    logic [2:0] seq7;
    // AM_PERIOD=8, GB_PERIOD=4
    logic       ready8, scr8, stall8, run8;
    logic [3:0] am8;
    logic [2:0] seq8;
    // defaults
    logic       readyd, scrd, stalld, rund;
    logic [3:0] amd;
    logic [5:0] seqd;

    int tests_run = 0;
    int tests_failed = 0;

    logic [10:0] q7[$];
    logic [10:0] q8[$];

    pcs_40g_tx_sched #(.AM_PERIOD(7), .GB_PERIOD(4)) u7 (
        .clk(clk), .reset(reset), .en_i(en_a),
        .ready_o(ready7), .scr_en_o(scr7), .am_v_o(am7),
        .gb_stall_o(stall7), .gb_seq_o(seq7), .run_o(run7)
    );

    pcs_40g_tx_sched #(.AM_PERIOD(8), .GB_PERIOD(4)) u8 (
        .clk(clk), .reset(reset), .en_i(en_a),
        .ready_o(ready8), .scr_en_o(scr8), .am_v_o(am8),
        .gb_stall_o(stall8), .gb_seq_o(seq8), .run_o(run8)
    );

    pcs_40g_tx_sched ud (
        .clk(clk), .reset(reset), .en_i(en_d),
        .ready_o(readyd), .scr_en_o(scrd), .am_v_o(amd),
        .gb_stall_o(stalld), .gb_seq_o(seqd), .run_o(rund)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] obs7();
        return {run7, am7, ready7, scr7, stall7, seq7};
    endfunction

    function automatic logic [10:0] obs8();
        return {run8, am8, ready8, scr8, stall8, seq8};
    endfunction

    // Expected outputs on cycle c (1 = first cycle after en_i sampled high),
    // built by walking the slots from a fresh start.
    function automatic logic [10:0] model(input int c, input int p, input int g);
        logic owed;
        int   n;
        int   seq;
        logic stall, am, dat;
        owed = 1'b1;
        n    = 0;
        for (int i = 1; i <= c; i++) begin
            seq   = (i - 1) % (g + 1);
            stall = (seq == g);
            am    = !stall && owed;
            dat   = !stall && !owed;
            if (i == c) return {1'b1, {4{am}}, dat, dat, stall, 3'(seq)};
            if (am) owed = 1'b0;
            if (dat) begin
                n++;
                if (n == p) begin
                    owed = 1'b1;
                    n    = 0;
                end
            end
        end
        return '0;
    endfunction

    initial begin
        int   data_cnt;
        int   am_seen;
        int   last_stall;
        logic exp_r;

        reset = 1'b1;
        en_a  = 1'b1;
        en_d  = 1'b0;

        // Reset held with enable high: everything stays quiet.
        step(); step(); step();
        check("reset u7", 32'(obs7()), 32'd0);
        check("reset u8", 32'(obs8()), 32'd0);
        reset = 1'b0;

        // Cadence, AM spacing and AM/stall collision from a fresh start.
        for (int c = 1; c <= 30; c++) begin
            q7.push_back(model(c, 7, 4));
            q8.push_back(model(c, 8, 4));
            step();
            check($sformatf("sb u7 cyc%0d", c), 32'(obs7()), 32'(q7.pop_front()));
            check($sformatf("sb u8 cyc%0d", c), 32'(obs8()), 32'(q8.pop_front()));
            check($sformatf("cadence u7 cyc%0d", c), {31'd0, stall7}, {31'd0, (c % 5) == 0});
            if (stall7) check($sformatf("stall seq cyc%0d", c), 32'(seq7), 32'd4);
            if (c == 1) check("first slot AM u7", {20'd0, run7, am7, ready7, seq7}, {20'd0, 1'b1, 4'hF, 1'b0, 3'd0});
            if (c == 10) check("collision stall u7", {27'd0, am7, stall7}, {27'd0, 4'h0, 1'b1});
            if (c == 11) check("deferred AM u7", {25'd0, am7, seq7}, {25'd0, 4'hF, 3'd0});
            if (c == 12) check("data after AM u7", {31'd0, ready7}, 32'd1);
            if (c <= 11) begin
                exp_r = (c >= 2 && c <= 4) || (c >= 6 && c <= 9) || (c == 11);
                check($sformatf("am8 ready cyc%0d", c), {31'd0, ready8}, {31'd0, exp_r});
            end
            if (c == 12) check("am8 AM at 12", {25'd0, am8, seq8}, {25'd0, 4'hF, 3'd1});
        end

        // Mid-operation reset.
        reset = 1'b1;
        step(); step();
        check("midop reset u7", 32'(obs7()), 32'd0);
        reset = 1'b0;

        // Enable drop sampled at cycle 6.
        for (int c = 1; c <= 6; c++) begin
            q7.push_back(model(c, 7, 4));
            step();
            check($sformatf("sb drop u7 cyc%0d", c), 32'(obs7()), 32'(q7.pop_front()));
        end
        en_a = 1'b0;
        step();
        check("en drop idle u7", 32'(obs7()), 32'd0);
        check("en drop idle u8", 32'(obs8()), 32'd0);
        en_a = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            q7.push_back(model(c, 7, 4));
            step();
            check($sformatf("sb reen u7 cyc%0d", c), 32'(obs7()), 32'(q7.pop_front()));
            if (c == 1) check("reen AM first", {25'd0, am7, seq7}, {25'd0, 4'hF, 3'd0});
        end
        en_a = 1'b0;

        // Default parameters: AM spacing, stall spacing, exclusivity.
        en_d       = 1'b1;
        data_cnt   = 0;
        am_seen    = 0;
        last_stall = -1;
        for (int c = 1; c <= 70000; c++) begin
            step();
            if (c == 1) check("dflt first AM", {27'd0, rund, amd}, {27'd0, 1'b1, 4'hF});
            check($sformatf("dflt excl cyc%0d", c), {31'd0, readyd && (amd != 4'h0)}, 32'd0);
            check($sformatf("dflt scr cyc%0d", c), {31'd0, scrd}, {31'd0, readyd});
            check($sformatf("dflt stall seq cyc%0d", c), {31'd0, stalld}, {31'd0, seqd == 6'd32});
            if (stalld) begin
                if (last_stall >= 0) check($sformatf("dflt stall gap cyc%0d", c), 32'(c - last_stall), 32'd33);
                last_stall = c;
            end
            if (readyd) data_cnt++;
            if (amd == 4'hF) begin
                if (am_seen > 0) check($sformatf("dflt AM gap cyc%0d", c), 32'(data_cnt), 32'd16383);
                am_seen++;
                data_cnt = 0;
            end
        end
        check("dflt AM count", {31'd0, am_seen >= 4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
